// File: rtl/delayed_line.sv
// delayed_line: programmable delay line carrying {valid, data} through MAX_DELAY register stages.
// Latency: delay_sel enabled cycles (0 = combinational bypass, >MAX_DELAY clamps to MAX_DELAY).
// Backpressure: none; en=0 freezes every stage, flush clears all valid bits at the next edge.
// Optional: define DELAYED_LINE_PARITY_EN to store a per-stage even-parity bit and add parity_err.
module delayed_line #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DELAY  = 4,
  parameter int SEL_WIDTH  = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic [SEL_WIDTH-1:0]  delay_sel,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef DELAYED_LINE_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_DELAY);

  // Stage storage, index 1 is the stage nearest the input.
  logic [DATA_WIDTH-1:0] stage_dat [1:MAX_DELAY];
  logic [MAX_DELAY:1]    stage_vld;
`ifdef DELAYED_LINE_PARITY_EN
  logic [MAX_DELAY:1]    stage_par;
`endif

  logic [SEL_WIDTH-1:0]  sel_eff;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_vld;
`ifdef DELAYED_LINE_PARITY_EN
  logic                  sel_par;
`endif

  // Data (and parity) shift on enabled edges; a flush freezes the data so stored words are retained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        stage_dat[k] <= '0;
      end
`ifdef DELAYED_LINE_PARITY_EN
      stage_par <= '0;
`endif
    end else if (en && !flush) begin
      stage_dat[1] <= data_in;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        stage_dat[k] <= stage_dat[k-1];
      end
`ifdef DELAYED_LINE_PARITY_EN
      stage_par[1] <= ^data_in;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        stage_par[k] <= stage_par[k-1];
      end
`endif
    end
  end

  // Valid bits shift with the data; flush wins over en and drops the word presented that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
    end else if (flush) begin
      stage_vld <= '0;
    end else if (en) begin
      stage_vld[1] <= valid_in;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        stage_vld[k] <= stage_vld[k-1];
      end
    end
  end

  // Clamp the requested delay and pick the matching stage.
  always_comb begin
    sel_eff = (delay_sel > MAX_SEL) ? MAX_SEL : delay_sel;
    sel_dat = '0;
    sel_vld = 1'b0;
`ifdef DELAYED_LINE_PARITY_EN
    sel_par = 1'b0;
`endif
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (sel_eff == SEL_WIDTH'(k)) begin
        sel_dat = stage_dat[k];
        sel_vld = stage_vld[k];
`ifdef DELAYED_LINE_PARITY_EN
        sel_par = stage_par[k];
`endif
      end
    end
  end

  // Delay 0 is a straight combinational bypass; otherwise drive the selected stage.
  always_comb begin
    if (delay_sel == '0) begin
      data_out  = data_in;
      valid_out = valid_in;
    end else begin
      data_out  = sel_dat;
      valid_out = sel_vld;
    end
  end

`ifdef DELAYED_LINE_PARITY_EN
  // Flag a stored word whose recomputed parity disagrees with the captured bit; never in bypass.
  always_comb begin
    parity_err = (delay_sel != '0) && sel_vld && ((^sel_dat) != sel_par);
  end
`endif

endmodule

// File: tb/tb_delayed_line.sv
// tb_delayed_line: directed self-checking bench for delayed_line (DATA_WIDTH=8, MAX_DELAY=4).
// Inputs are driven 1ns after each rising edge; outputs are sampled at the same point.
// Each task covers one scenario and carries its own hand-computed expectations.
module tb_delayed_line;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [2:0] delay_sel;
  logic       valid_in;
  logic [7:0] data_in;
  logic       valid_out;
  logic [7:0] data_out;
`ifdef DELAYED_LINE_PARITY_EN
  logic       parity_err;
`endif

  int pass_cnt = 0;
  int total    = 0;

  delayed_line #(.DATA_WIDTH(8), .MAX_DELAY(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .delay_sel (delay_sel),
    .valid_in  (valid_in),
    .data_in   (data_in),
`ifdef DELAYED_LINE_PARITY_EN
    .parity_err(parity_err),
`endif
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push invalid zero words so the pipeline holds nothing valid.
  task automatic drain(input int n);
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    flush     = 1'b0;
    delay_sel = 3'd1;
    valid_in  = 1'b1;
    data_in   = 8'hFF;
    #1;
    total++;
    if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out);
    else pass_cnt++;
    total++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out);
    else pass_cnt++;
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_delay1();
    logic [7:0] prev;
    delay_sel = 3'd1;
    en        = 1'b1;
    valid_in  = 1'b1;
    data_in   = 8'h01;
    prev      = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (data_out !== prev || valid_out !== 1'b1)
        $display("FAIL delay1_step%0d: got %h/%b want %h/1", i, data_out, valid_out, prev);
      else pass_cnt++;
      data_in = (prev == 8'h01) ? 8'h00 : 8'h01;
      prev    = data_in;
    end
  endtask

  task automatic test_full_depth();
    delay_sel = 3'd4;
    drain(4);
    total++;
    if (valid_out !== 1'b0) $display("FAIL depth_pre: got valid %b want 0", valid_out);
    else pass_cnt++;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        valid_in = 1'b0;
        data_in  = 8'h00;
      end
      total++;
      if (i == 4) begin
        if (valid_out !== 1'b1 || data_out !== 8'hA5)
          $display("FAIL depth_edge4: got %h/%b want A5/1", data_out, valid_out);
        else pass_cnt++;
      end else begin
        if (valid_out !== 1'b0)
          $display("FAIL depth_edge%0d: got valid %b want 0", i, valid_out);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stall();
    delay_sel = 3'd2;
    en        = 1'b1;
    drain(2);
    valid_in = 1'b1;
    data_in  = 8'h3C;
    tick();
    valid_in = 1'b0;
    data_in  = 8'h00;
    en       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid_out !== 1'b0 || data_out !== 8'h00)
        $display("FAIL stall_hold%0d: got %h/%b want 00/0", i, data_out, valid_out);
      else pass_cnt++;
    end
    en = 1'b1;
    tick();
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h3C)
      $display("FAIL stall_emerge: got %h/%b want 3C/1", data_out, valid_out);
    else pass_cnt++;
    tick();
    total++;
    if (valid_out !== 1'b0) $display("FAIL stall_after: got valid %b want 0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    delay_sel = 3'd4;
    en        = 1'b1;
    drain(4);
    valid_in = 1'b1;
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    data_in = 8'h33; tick();
    data_in = 8'h44;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    total++;
    if (valid_out !== 1'b0) $display("FAIL flush_now: got valid %b want 0", valid_out);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (valid_out !== 1'b0) $display("FAIL flush_idle%0d: got valid %b want 0", i, valid_out);
      else pass_cnt++;
    end
    valid_in = 1'b1;
    data_in  = 8'h55;
    tick();
    valid_in = 1'b0;
    data_in  = 8'h00;
    tick(); tick(); tick();
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h55)
      $display("FAIL flush_new: got %h/%b want 55/1", data_out, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    delay_sel = 3'd0;
    valid_in  = 1'b1;
    data_in   = 8'h5A;
    #1;
    total++;
    if (data_out !== 8'h5A || valid_out !== 1'b1)
      $display("FAIL bypass_a: got %h/%b want 5A/1", data_out, valid_out);
    else pass_cnt++;
    valid_in = 1'b0;
    data_in  = 8'hC3;
    #1;
    total++;
    if (data_out !== 8'hC3 || valid_out !== 1'b0)
      $display("FAIL bypass_b: got %h/%b want C3/0", data_out, valid_out);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_clamp();
    delay_sel = 3'd7;
    en        = 1'b1;
    drain(4);
    valid_in = 1'b1;
    data_in  = 8'h96;
    tick();
    valid_in = 1'b0;
    data_in  = 8'h00;
    tick(); tick();
    total++;
    if (valid_out !== 1'b0) $display("FAIL clamp_edge3: got valid %b want 0", valid_out);
    else pass_cnt++;
    tick();
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h96)
      $display("FAIL clamp_edge4: got %h/%b want 96/1", data_out, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    delay_sel = 3'd1;
    en        = 1'b1;
    valid_in  = 1'b1;
    data_in   = 8'h77;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (data_out !== 8'h00 || valid_out !== 1'b0)
      $display("FAIL reset_mid: got %h/%b want 00/0", data_out, valid_out);
    else pass_cnt++;
    #10;
    rst_n = 1'b1;
    tick();
  endtask

`ifdef DELAYED_LINE_PARITY_EN
  task automatic test_parity();
    delay_sel = 3'd2;
    en        = 1'b1;
    drain(2);
    valid_in = 1'b1;
    data_in  = 8'h5B;
    tick();
    valid_in = 1'b0;
    data_in  = 8'h00;
    tick();
    total++;
    if (valid_out !== 1'b1 || parity_err !== 1'b0)
      $display("FAIL parity_clean: got v=%b err=%b want v=1 err=0", valid_out, parity_err);
    else pass_cnt++;
    en = 1'b0;
    dut.stage_dat[2] = dut.stage_dat[2] ^ 8'h01;
    #1;
    total++;
    if (parity_err !== 1'b1) $display("FAIL parity_corrupt: got err=%b want 1", parity_err);
    else pass_cnt++;
    en = 1'b1;
    drain(2);
  endtask
`endif

  initial begin
    test_reset();
    test_delay1();
    test_full_depth();
    test_stall();
    test_flush();
    test_bypass();
    test_clamp();
    test_reset_midstream();
`ifdef DELAYED_LINE_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
